// File: rtl/lbist_sig_checker.sv
// Multi-channel LBIST signature checker: captures CHANNELS signature/golden pairs,
// compares them one channel per clock with masking and optional stop-on-first-fail.
module lbist_sig_checker #(
  parameter  int RC_BITS  = 8,
  parameter  int CHANNELS = 4,
  parameter  int CNT_BITS = 4,
  localparam int IDX_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         sig_valid,
  input  logic [CHANNELS*RC_BITS-1:0]  rc_op,
  input  logic [CHANNELS*RC_BITS-1:0]  ff_sig,
  input  logic [CHANNELS-1:0]          ch_mask,
  input  logic                         stop_on_fail,
  input  logic                         clr_sticky,
  output logic                         busy,
  output logic                         done,
  output logic                         res,
  output logic [CNT_BITS-1:0]          fail_count,
  output logic [IDX_BITS-1:0]          fail_ch,
  output logic                         sticky_fail
);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, REPORT} state_t;

  state_t                        r_state;
  logic [IDX_BITS-1:0]           r_idx;
  logic                          r_sof;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_res;
  logic [CNT_BITS-1:0]           r_fail_count;
  logic [IDX_BITS-1:0]           r_fail_ch;
  logic                          r_sticky;
  logic [CHANNELS*RC_BITS-1:0]   r_rc;
  logic [CHANNELS*RC_BITS-1:0]   r_ff;
  logic [CHANNELS-1:0]           r_mask;

  logic [RC_BITS-1:0]            w_rc_ch;
  logic [RC_BITS-1:0]            w_ff_ch;
  logic                          w_mismatch;
  logic                          w_last;
  logic                          w_cnt_sat;

  assign w_rc_ch    = r_rc[r_idx*RC_BITS +: RC_BITS];
  assign w_ff_ch    = r_ff[r_idx*RC_BITS +: RC_BITS];
  assign w_mismatch = (r_state == COMPARE) && !r_mask[r_idx] && (w_rc_ch != w_ff_ch);
  assign w_last     = (r_idx == IDX_BITS'(CHANNELS - 1));
  assign w_cnt_sat  = &r_fail_count;

  // Signature buffers carry no reset: they are only read after a capture.
  always_ff @(posedge clk) begin
    if (r_state == CAPTURE && sig_valid) begin
      r_rc   <= rc_op;
      r_ff   <= ff_sig;
      r_mask <= ch_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_sof        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_res        <= 1'b0;
      r_fail_count <= '0;
      r_fail_ch    <= '0;
      r_sticky     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A mismatch in the same cycle as clr_sticky keeps the flag set.
      if (w_mismatch)      r_sticky <= 1'b1;
      else if (clr_sticky) r_sticky <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= CAPTURE;
            r_busy       <= 1'b1;
            r_fail_count <= '0;
            r_fail_ch    <= '0;
            r_res        <= 1'b0;
            r_sof        <= stop_on_fail;
          end
        end
        CAPTURE: begin
          if (sig_valid) begin
            r_idx   <= '0;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_mismatch) begin
            if (!w_cnt_sat)          r_fail_count <= r_fail_count + 1'b1;
            if (r_fail_count == '0)  r_fail_ch    <= r_idx;
          end
          if ((w_mismatch && r_sof) || w_last) begin
            r_state <= REPORT;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        REPORT: begin
          r_done  <= 1'b1;
          r_res   <= (r_fail_count == '0);
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign res         = r_res;
  assign fail_count  = r_fail_count;
  assign fail_ch     = r_fail_ch;
  assign sticky_fail = r_sticky;

endmodule

// File: tb/tb_lbist_sig_checker.sv
// Self-checking bench for lbist_sig_checker: directed vector table, corner-case
// sequences and randomized runs against a channel-list reference model.
module tb_lbist_sig_checker;
  localparam int CH = 4;
  localparam int RB = 8;
  localparam int CB = 4;
  localparam int IB = 2;
  localparam int W  = CH * RB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, sig_valid, stop_on_fail, clr_sticky;
  logic [W-1:0]  rc_op, ff_sig;
  logic [CH-1:0] ch_mask;
  logic          busy, done, res, sticky_fail;
  logic [CB-1:0] fail_count;
  logic [IB-1:0] fail_ch;

  int n_vec = 0;
  int n_err = 0;
  logic exp_sticky = 1'b0;

  lbist_sig_checker #(.RC_BITS(RB), .CHANNELS(CH), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sig_valid(sig_valid),
    .rc_op(rc_op), .ff_sig(ff_sig), .ch_mask(ch_mask), .stop_on_fail(stop_on_fail),
    .clr_sticky(clr_sticky), .busy(busy), .done(done), .res(res),
    .fail_count(fail_count), .fail_ch(fail_ch), .sticky_fail(sticky_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  rc;
    logic [W-1:0]  ff;
    logic [CH-1:0] mask;
    logic          sof;
    logic          e_res;
    int            e_cnt;
    int            e_ch;
    int            e_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: list the failing unmasked channels, then apply the run rules.
  task automatic model(input logic [W-1:0] rc, input logic [W-1:0] ff, input logic [CH-1:0] mask,
                       input logic sof, output logic e_res, output int e_cnt, output int e_ch,
                       output int e_lat);
    int q[$];
    int n;
    for (int c = 0; c < CH; c++)
      if (!mask[c] && rc[c*RB +: RB] != ff[c*RB +: RB]) q.push_back(c);
    n = q.size();
    if (sof && n > 1) n = 1;
    e_cnt = (n > (1 << CB) - 1) ? (1 << CB) - 1 : n;
    e_ch  = (n > 0) ? q[0] : 0;
    e_res = (n == 0);
    e_lat = (sof && n > 0) ? q[0] + 2 : CH + 1;
  endtask

  task automatic run(input string tag, input logic [W-1:0] rc, input logic [W-1:0] ff,
                     input logic [CH-1:0] mask, input logic sof, input int clr_at,
                     input int start_at, input logic e_res, input int e_cnt, input int e_ch,
                     input int e_lat);
    int  n;
    logic overlap;
    @(negedge clk);
    start = 1'b1;
    stop_on_fail = sof;
    @(posedge clk); #1;
    start = 1'b0;
    stop_on_fail = ~sof;
    chk({tag, " busy_after_start"}, busy, 1'b1);
    @(negedge clk);
    rc_op = rc; ff_sig = ff; ch_mask = mask; sig_valid = 1'b1;
    @(posedge clk); #1;
    sig_valid = 1'b0;
    rc_op = $urandom; ff_sig = $urandom; ch_mask = $urandom;
    n = 0;
    overlap = 1'b0;
    while (n < 20) begin
      clr_sticky = (clr_at == n + 1);
      start      = (start_at == n + 1);
      @(posedge clk); #1;
      n++;
      if (busy && done) overlap = 1'b1;
      if (done) break;
    end
    clr_sticky = 1'b0;
    start = 1'b0;
    if (!done) begin
      chk({tag, " done_timeout"}, 1'b0, 1'b1);
      return;
    end
    if (e_cnt != 0) exp_sticky = 1'b1;
    chk({tag, " latency"}, n, e_lat);
    chk({tag, " res"}, res, e_res);
    chk({tag, " fail_count"}, fail_count, e_cnt);
    chk({tag, " fail_ch"}, fail_ch, e_ch);
    chk({tag, " sticky"}, sticky_fail, exp_sticky);
    chk({tag, " busy_done_overlap"}, overlap, 1'b0);
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, {busy, done}, 2'b00);
    chk({tag, " res_held"}, res, e_res);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    exp_sticky = 1'b0;
    chk("clr_sticky_pulse", sticky_fail, 1'b0);
  endtask

  vec_t tbl[7];

  initial begin
    logic e_res;
    int   e_cnt, e_ch, e_lat;
    logic [W-1:0] rr, ff;
    logic [CH-1:0] mm;
    logic ss;
    logic seen_done;

    tbl[0] = '{rc: 32'hFCFC_FCFC, ff: 32'hFCFC_FCFC, mask: 4'b0000, sof: 1'b0, e_res: 1'b1, e_cnt: 0, e_ch: 0, e_lat: 5};
    tbl[1] = '{rc: 32'hFF00_FCFC, ff: 32'hFCFC_FCFC, mask: 4'b0000, sof: 1'b0, e_res: 1'b0, e_cnt: 2, e_ch: 2, e_lat: 5};
    tbl[2] = '{rc: 32'hFF00_FCFC, ff: 32'hFCFC_FCFC, mask: 4'b0000, sof: 1'b1, e_res: 1'b0, e_cnt: 1, e_ch: 2, e_lat: 4};
    tbl[3] = '{rc: 32'hFF00_FCFC, ff: 32'hFCFC_FCFC, mask: 4'b1100, sof: 1'b0, e_res: 1'b1, e_cnt: 0, e_ch: 0, e_lat: 5};
    tbl[4] = '{rc: 32'h0000_0000, ff: 32'hFFFF_FFFF, mask: 4'b1111, sof: 1'b0, e_res: 1'b1, e_cnt: 0, e_ch: 0, e_lat: 5};
    tbl[5] = '{rc: 32'h0000_0000, ff: 32'hFFFF_FFFF, mask: 4'b0000, sof: 1'b1, e_res: 1'b0, e_cnt: 1, e_ch: 0, e_lat: 2};
    tbl[6] = '{rc: 32'h1234_5678, ff: 32'h1234_0078, mask: 4'b0001, sof: 1'b0, e_res: 1'b0, e_cnt: 1, e_ch: 1, e_lat: 5};

    rst_n = 1'b0; start = 1'b0; sig_valid = 1'b0; stop_on_fail = 1'b0; clr_sticky = 1'b0;
    rc_op = '0; ff_sig = '0; ch_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, res, fail_count, fail_ch, sticky_fail}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run($sformatf("tbl%0d", i), tbl[i].rc, tbl[i].ff, tbl[i].mask, tbl[i].sof, 0, 0,
          tbl[i].e_res, tbl[i].e_cnt, tbl[i].e_ch, tbl[i].e_lat);

    // Sticky survives a passing run, then clears on request.
    run("pass_keeps_sticky", 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b0000, 1'b0, 0, 0, 1'b1, 0, 0, 5);
    clr_pulse();

    // Channel 2 mismatch compared on the same edge clr_sticky is high.
    run("clr_vs_set", 32'hFC00_FCFC, 32'hFCFC_FCFC, 4'b0000, 1'b0, 3, 0, 1'b0, 1, 2, 5);

    // start during COMPARE must not extend or restart the run.
    run("start_in_compare", 32'hFF00_FCFC, 32'hFCFC_FCFC, 4'b0000, 1'b0, 0, 2, 1'b0, 2, 2, 5);

    // Reset mid-run after channel 0 has already failed.
    @(negedge clk);
    start = 1'b1; stop_on_fail = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rc_op = 32'h0000_0000; ff_sig = 32'hFFFF_FFFF; ch_mask = 4'b0000; sig_valid = 1'b1;
    @(posedge clk); #1;
    sig_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrun_sticky_before_reset", sticky_fail, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy, done, res, fail_count, fail_ch, sticky_fail}, '0);
    seen_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("midrun_no_done", seen_done, 1'b0);
    exp_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run("after_midrun_reset", 32'hFCFC_FCFC, 32'hFCFC_FCFC, 4'b0000, 1'b0, 0, 0, 1'b1, 0, 0, 5);

    for (int r = 0; r < 40; r++) begin
      rr = {$urandom};
      ff = rr;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 1) == 1) ff[c*RB +: RB] = 8'($urandom);
      mm = 4'($urandom);
      ss = 1'($urandom);
      model(rr, ff, mm, ss, e_res, e_cnt, e_ch, e_lat);
      run($sformatf("rnd%0d", r), rr, ff, mm, ss, 0, 0, e_res, e_cnt, e_ch, e_lat);
      if (r % 7 == 6) clr_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
